// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: walks a word range on the host req/ack bus,
// writes a pattern, reads it back and reports pass/fail and error stats.
module mem_bist_initiator #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] seed,
  output logic              host_req,
  output logic              host_wr_en,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] host_rdata,
  input  logic              host_ack,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN
  } state_t;

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(32'h80200003);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] nw_q, nw_d;
  logic [15:0] err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic [1:0] psel_q, psel_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic tmo_q, tmo_d;
  logic pass_q, pass_d;

  logic [ADDR_W-1:0] off, addr;
  logic [DATA_W-1:0] idx_ext, pat, lfsr_nx, seed0;
  logic [15:0] idx_nx;

  assign off     = ADDR_W'({idx_q, 2'b00});
  assign addr    = base_q + off;
  assign idx_ext = DATA_W'(idx_q);
  assign idx_nx  = idx_q + 16'd1;
  assign lfsr_nx = {1'b0, lfsr_q[DATA_W-1:1]}
                 ^ (lfsr_q[0] ? TAPS : '0);
  assign seed0   = (seed == '0) ? DATA_W'(1) : seed;

  always_comb begin
    case (psel_q)
      2'd0:    pat = idx_ext;
      2'd1:    pat = DATA_W'(32'h55AA0000) | idx_ext;
      2'd2:    pat = lfsr_q;
      default: pat = DATA_W'(addr[ADDR_W-1:2]);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nw_q    <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      ferr_q  <= '0;
      psel_q  <= '0;
      lfsr_q  <= '0;
      seed_q  <= '0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      ferr_q  <= ferr_d;
      psel_q  <= psel_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    nw_d     = nw_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    ferr_d   = ferr_q;
    psel_d   = psel_q;
    lfsr_d   = lfsr_q;
    seed_d   = seed_q;
    tmo_d    = tmo_q;
    pass_d   = pass_q;
    host_req = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d  = '0;
          ferr_d = '0;
          tmo_d  = 1'b0;
          pass_d = 1'b0;
          idx_d  = '0;
          cnt_d  = '0;
          nw_d   = num_words;
          base_d = base_addr & ~ADDR_W'(3);
          psel_d = pattern_sel;
          lfsr_d = seed0;
          seed_d = seed0;
          if (num_words == 16'd0)
            state_d = FIN;
          else if (pattern_sel == 2'd3)
            state_d = RD_REQ;
          else
            state_d = WR_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        host_req = 1'b1;
        if (host_ack) begin
          if (state_q == RD_REQ && host_rdata != pat) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) ferr_d = addr;
          end
          state_d = (state_q == WR_REQ) ? WR_GAP : RD_GAP;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WR_GAP, RD_GAP: begin
        if (!host_ack) begin
          cnt_d  = '0;
          lfsr_d = lfsr_nx;
          idx_d  = idx_nx;
          if (idx_nx != nw_q)
            state_d = (state_q == WR_GAP) ? WR_REQ : RD_REQ;
          else if (state_q == WR_GAP) begin
            idx_d   = '0;
            lfsr_d  = seed_q;
            state_d = RD_REQ;
          end else
            state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        pass_d  = (err_q == 16'd0) && !tmo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign host_wr_en     = (state_q == WR_REQ);
  assign host_addr      = host_req ? addr : '0;
  assign host_wdata     = host_wr_en ? pat : '0;
  assign busy           = (state_q != IDLE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign timeout_err    = tmo_q;

endmodule
